// File: rtl/data_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte write FIFO on the CPU data bus.
// Reads are combinational so a single-cycle core can poll STATUS with the load.
module data_bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFF20_0100,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] oReadData,
  output logic        oTX,
  output logic        oIRQ
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [1:0]      ctrl;
  logic [BW-1:0]   baud, baud_d;
  logic [2:0]      bitidx, bitidx_d;
  logic [7:0]      shreg, shreg_d;
  logic            tx_q, tx_d;
  logic            pop;

  // Address decode and register strobes
  logic       sel, full, empty, busy, bit_end;
  logic       wr_data, wr_ovf_clr, wr_ctrl, push;
  logic [1:0] off;

  assign sel        = (DwAddress[31:4] == BASE_ADDR[31:4]);
  assign off        = DwAddress[3:2];
  assign wr_data    = sel && DwWriteEnable && (off == 2'd0) && DwByteEnable[0];
  assign wr_ovf_clr = sel && DwWriteEnable && (off == 2'd1) && DwByteEnable[1] && DwWriteData[13];
  assign wr_ctrl    = sel && DwWriteEnable && (off == 2'd2) && DwByteEnable[0];
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = wr_data && !full;
  assign busy       = (state != S_IDLE);
  assign bit_end    = (baud == BW'(CLK_DIV - 1));

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // FIFO pointers, occupancy and software-visible registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      ctrl  <= 2'b01;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count + CW'(push) - CW'(pop);
      if (wr_data && full) ovf <= 1'b1;
      else if (wr_ovf_clr) ovf <= 1'b0;
      if (wr_ctrl) ctrl <= DwWriteData[1:0];
    end
  end

  // Storage is not reset; only valid entries are ever read
  always_ff @(posedge iCLK) begin
    if (push) mem[wptr] <= DwWriteData[7:0];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (ctrl[0] && !empty)          state_d = S_START;
      S_START: if (bit_end)                    state_d = S_DATA;
      S_DATA:  if (bit_end && bitidx == 3'd7)  state_d = S_STOP;
      S_STOP:  if (bit_end)                    state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Line value is derived from next-state values so oTX can be a plain flop
  always_comb begin
    pop      = 1'b0;
    shreg_d  = shreg;
    baud_d   = baud + BW'(1);
    bitidx_d = bitidx;
    tx_d     = 1'b1;
    if (state == S_IDLE && state_d == S_START) begin
      pop     = 1'b1;
      shreg_d = mem[rptr];
    end
    if (state_d != state || bit_end || state == S_IDLE) baud_d = '0;
    if (state_d != S_DATA)              bitidx_d = '0;
    else if (state == S_DATA && bit_end) bitidx_d = bitidx + 3'd1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[bitidx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      baud   <= '0;
      bitidx <= '0;
      shreg  <= '0;
      tx_q   <= 1'b1;
    end else begin
      baud   <= baud_d;
      bitidx <= bitidx_d;
      shreg  <= shreg_d;
      tx_q   <= tx_d;
    end
  end

  // Zero outside the window so the bus can OR this with memory read data
  always_comb begin
    oReadData = '0;
    if (sel && DwReadEnable) begin
      case (off)
        2'd1:    oReadData = {18'd0, ovf, 5'(count), 5'd0, busy, empty, full};
        2'd2:    oReadData = {30'd0, ctrl};
        default: oReadData = '0;
      endcase
    end
  end

  assign oTX  = tx_q;
  assign oIRQ = ctrl[1] && empty && (state == S_IDLE);

  logic unused_bits;
  assign unused_bits = ^{DwAddress[1:0], DwByteEnable[3:2], DwWriteData[31:14], DwWriteData[12:8]};

endmodule

// File: tb/tb_data_bus_uart_tx.sv
// Self-checking bench for data_bus_uart_tx: a small instance (CLK_DIV=4, depth 4)
// and a default-parameter instance sharing one bus, checked against a queue model.
module tb_data_bus_uart_tx;

  localparam logic [31:0] BASE = 32'hFF20_0100;
  localparam int DIV   = 4;
  localparam int DEP   = 4;
  localparam int DIV_B = 434;
  localparam int DEP_B = 16;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd_a, rd_b;
  logic        tx_a, tx_b, irq_a, irq_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic       ovf_m = 1'b0;
  logic [7:0] cur;

  always #5 iCLK = ~iCLK;

  data_bus_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEP)) u_a (
    .iCLK(iCLK), .iRST(iRST), .DwReadEnable(re), .DwWriteEnable(we),
    .DwByteEnable(be), .DwAddress(addr), .DwWriteData(wd),
    .oReadData(rd_a), .oTX(tx_a), .oIRQ(irq_a)
  );

  data_bus_uart_tx u_b (
    .iCLK(iCLK), .iRST(iRST), .DwReadEnable(re), .DwWriteEnable(we),
    .DwByteEnable(be), .DwAddress(addr), .DwWriteData(wd),
    .oReadData(rd_b), .oTX(tx_b), .oIRQ(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge and drop the strobes
  task automatic tick();
    @(posedge iCLK);
    #1;
    we = 1'b0;
    re = 1'b0;
    be = 4'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a;
    wd   = d;
    be   = b;
    we   = 1'b1;
    tick();
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input bit on_b, input logic [31:0] exp);
    addr = a;
    re   = 1'b1;
    #1;
    chk(tag, on_b ? rd_b : rd_a, exp);
    re   = 1'b0;
  endtask

  // Model push: a push into a full FIFO is lost and flags overflow
  task automatic push(input logic [7:0] d);
    if (q.size() == DEP) ovf_m = 1'b1;
    else q.push_back(d);
    wr(BASE, {24'd0, d}, 4'b0001);
  endtask

  function automatic logic [31:0] exp_status(input bit busy, input int dep);
    int n;
    n = q.size();
    return {18'd0, ovf_m, 5'(n), 5'd0, busy, (n == 0), (n == dep)};
  endfunction

  // Serial frame: start 0, eight data bits LSB first, stop 1, DIV cycles each
  task automatic frame_chk(input logic [7:0] b, input int from);
    for (int i = from; i < 10 * DIV; i++) begin
      int   k;
      logic e;
      k = i / DIV;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      if (i == 0) rdchk("status_in_frame", BASE + 32'd4, 1'b0, exp_status(1'b1, DEP));
      chk("tx_a", 32'(tx_a), 32'(e));
      tick();
    end
  endtask

  // Drain the model queue; called in the first START cycle, ends in the final IDLE cycle
  task automatic run_frames();
    while (q.size() > 0) begin
      cur = q.pop_front();
      frame_chk(cur, 0);
      rdchk("status_idle_gap", BASE + 32'd4, 1'b0, exp_status(1'b0, DEP));
      chk("tx_idle_gap", 32'(tx_a), 32'd1);
      if (q.size() > 0) tick();
    end
  endtask

  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;

    // Reset state and basic decode on the small instance
    chk("reset_tx", 32'(tx_a), 32'd1);
    chk("reset_irq", 32'(irq_a), 32'd0);
    rdchk("reset_status", BASE + 32'd4, 1'b0, 32'h0000_0002);
    rdchk("reset_ctrl", BASE + 32'd8, 1'b0, 32'h0000_0001);
    rdchk("data_reads_zero", BASE, 1'b0, 32'd0);
    rdchk("off3_reads_zero", BASE + 32'd12, 1'b0, 32'd0);
    addr = BASE + 32'd4;
    re   = 1'b0;
    #1;
    chk("no_read_enable", rd_a, 32'd0);

    // Single byte 0x55: line idle in cycles 0-1, start bit from cycle 2
    tick();
    chk("tx_cycle0", 32'(tx_a), 32'd1);
    push(8'h55);
    chk("tx_cycle1", 32'(tx_a), 32'd1);
    tick();
    run_frames();
    rdchk("single_done", BASE + 32'd4, 1'b0, 32'h0000_0002);
    chk("irq_disabled", 32'(irq_a), 32'd0);

    // Overflow with EN cleared, then OVF clear and drain in order
    wr(BASE + 32'd8, 32'd0, 4'b0001);
    for (int i = 1; i <= 5; i++) push(8'(i));
    rdchk("ovf_status_model", BASE + 32'd4, 1'b0, exp_status(1'b0, DEP));
    rdchk("ovf_status_const", BASE + 32'd4, 1'b0, 32'h0000_2401);
    wr(BASE + 32'd4, 32'h0000_2000, 4'b0010);
    ovf_m = 1'b0;
    rdchk("ovf_cleared", BASE + 32'd4, 1'b0, 32'h0000_0401);
    wr(BASE + 32'd8, 32'd1, 4'b0001);
    tick();
    run_frames();

    // Randomised rounds: queue random bytes with EN low, then release them
    for (int r = 0; r < 4; r++) begin
      int k;
      wr(BASE + 32'd8, 32'd0, 4'b0001);
      k = int'($urandom_range(1, 4));
      for (int j = 0; j < k; j++) push(8'($urandom));
      rdchk("rand_status", BASE + 32'd4, 1'b0, exp_status(1'b0, DEP));
      wr(BASE + 32'd8, 32'd1, 4'b0001);
      tick();
      run_frames();
    end

    // Push at full in the same cycle as the pop edge is dropped
    push(8'($urandom));
    tick();
    cur = q.pop_front();
    rdchk("inflight_status", BASE + 32'd4, 1'b0, exp_status(1'b1, DEP));
    for (int j = 0; j < 4; j++) push(8'($urandom));
    frame_chk(cur, 4);
    rdchk("full_before_pop", BASE + 32'd4, 1'b0, 32'h0000_0401);
    push(8'hAA);
    rdchk("drop_at_pop", BASE + 32'd4, 1'b0, 32'h0000_2304);
    run_frames();
    wr(BASE + 32'd4, 32'h0000_2000, 4'b0010);
    ovf_m = 1'b0;

    // Reset asserted during DATA bit 3 with a non-empty FIFO and OVF set
    wr(BASE + 32'd8, 32'd2, 4'b0001);
    push(8'($urandom) & 8'hF7);
    for (int j = 0; j < 4; j++) push(8'($urandom));
    wr(BASE + 32'd8, 32'd3, 4'b0001);
    tick();
    cur = q.pop_front();
    repeat (17) tick();
    chk("bit3_before_reset", 32'(tx_a), 32'(cur[3]));
    iRST = 1'b1;
    #1;
    chk("reset_async_tx", 32'(tx_a), 32'd1);
    chk("reset_async_irq", 32'(irq_a), 32'd0);
    rdchk("reset_async_status", BASE + 32'd4, 1'b0, 32'h0000_0002);
    rdchk("reset_async_ctrl", BASE + 32'd8, 1'b0, 32'h0000_0001);
    iRST = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    tick();

    // Default-parameter instance: decode, byte lanes and IRQ
    rdchk("b_status_idle", 32'hFF20_0104, 1'b1, 32'h0000_0002);
    rdchk("b_outside_window", 32'hFF20_0110, 1'b1, 32'd0);
    wr(BASE, 32'h0000_7700, 4'b0010);
    rdchk("b_lane1_not_pushed", BASE + 32'd4, 1'b1, 32'h0000_0002);
    wr(BASE + 32'd8, 32'd3, 4'b0001);
    rdchk("b_ctrl", BASE + 32'd8, 1'b1, 32'h0000_0003);
    chk("b_irq_idle_empty", 32'(irq_b), 32'd1);
    cur = 8'($urandom);
    addr = BASE;
    wd   = {24'd0, cur};
    be   = 4'b0001;
    we   = 1'b1;
    tick();
    chk("b_irq_pending", 32'(irq_b), 32'd0);
    chk("b_tx_before_start", 32'(tx_b), 32'd1);
    tick();
    for (int i = 0; i < 10 * DIV_B; i++) begin
      int   k;
      logic e;
      k = i / DIV_B;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur[k-1];
      if (i % DIV_B == 0 || i % DIV_B == DIV_B - 1) chk("tx_b", 32'(tx_b), 32'(e));
      if (i % 64 == 0) chk("b_irq_in_frame", 32'(irq_b), 32'd0);
      tick();
    end
    chk("b_irq_after_stop", 32'(irq_b), 32'd1);
    chk("b_tx_after_stop", 32'(tx_b), 32'd1);
    q.delete();
    rdchk("b_status_after", BASE + 32'd4, 1'b1, exp_status(1'b0, DEP_B));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_uart_tx.md
# data_bus_uart_tx

Memory-mapped UART transmitter with a write FIFO that sits directly downstream of the CPU data bus. It decodes its own address window, accepts byte writes from store instructions, and serialises them 8N1 on a single TX pin. Reads are combinational, so the single-cycle datapath can poll status in the same cycle it issues the load. Outputs return zero outside the window so `oReadData` can be OR-merged into `DwReadData` alongside data memory.

## Interface
- `BASE_ADDR`, 32'hFF20_0100: window base; decode is `DwAddress[31:4] == BASE_ADDR[31:4]`.
- `CLK_DIV`, 434: clocks per bit (50 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, 16: power of 2, ≤ 16.
- `iCLK` in 1: single clock. Everything is clocked on the rising edge.
- `iRST` in 1: reset, asynchronous and active-high.
- `DwReadEnable` in 1: load strobe.
- `DwWriteEnable` in 1: store strobe.
- `DwByteEnable` in 4: byte lanes of the store.
- `DwAddress` in 32: byte address.
- `DwWriteData` in 32: store data.
- `oReadData` out 32: combinational read data; 0 when not selected or when `DwReadEnable`=0.
- `oTX` out 1: serial line, idle high.
- `oIRQ` out 1: transmit-done interrupt, level.

## Operation
- **Register map.** Offset is `DwAddress[3:2]`; offset 3 reads 0 and ignores writes.
  - **0x0 DATA (write-only).**
    - A store with `DwByteEnable[0]`=1 pushes `DwWriteData[7:0]`.
    - A push while full is dropped and sets `OVF`.
    - Reads return 0.
  - **0x4 STATUS.**
    - Read bits: [0] full, [1] empty, [2] busy (FSM not IDLE), [7:3] 0, [12:8] count, [13] `OVF` (sticky).
    - A store with `DwByteEnable[1]`=1 and `DwWriteData[13]`=1 clears `OVF`.
  - **0x8 CTRL (R/W).**
    - Bit [0] `EN`, bit [1] `IRQEN`.
    - Written from `DwWriteData[1:0]` when `DwByteEnable[0]`=1.
    - Reset value 2'b01.
- **FIFO.**
  - Circular buffer with read/write pointers and a `count` of width log2(`FIFO_DEPTH`)+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - Full is evaluated on the pre-edge `count`. A push while full is dropped even if a pop occurs in the same cycle.
- **TX FSM states.**
  - **IDLE:** `oTX`=1. If `EN` && !empty, pop into `shreg` and go to START.
  - **START:** `oTX`=0 for `CLK_DIV` cycles, then go to DATA with `bitidx`=0.
  - **DATA:** `oTX`=`shreg[bitidx]`, LSB first, `CLK_DIV` cycles per bit. After bit 7 go to STOP.
  - **STOP:** `oTX`=1 for `CLK_DIV` cycles, then go to IDLE.
- **Baud counter.**
  - Counts 0..`CLK_DIV`-1, is cleared on every state change, and a bit ends when it reaches `CLK_DIV`-1.
  - Width is $clog2(`CLK_DIV`).
- **`EN` cleared mid-frame:** the current frame completes. No further pops occur until `EN` returns to 1.
- **`oIRQ`** = `IRQEN` && empty && state==IDLE.
- **Reset** (any time, including mid-frame):
  - FIFO is emptied, FSM goes to IDLE, `OVF` is cleared, `CTRL`=2'b01.
  - `oTX`=1 and `oIRQ`=0 immediately, without waiting for a clock edge.
  - FIFO storage contents need not be reset.

## Timing
- `oReadData` is combinational from `DwAddress`/`DwReadEnable` and the current register state. It reflects the state before the edge of the current cycle, so a push in cycle n is visible in STATUS in cycle n+1.
- `oTX` is registered (glitch-free).
- **Write-to-line latency:** a store in cycle n with an IDLE FSM and `EN`=1 gives:
  - push at end of cycle n;
  - pop and IDLE→START at end of cycle n+1;
  - `oTX` low from cycle n+2.
- **Frame length:** exactly 10·`CLK_DIV` cycles.
- **Back-to-back:** with a non-empty FIFO there is exactly 1 IDLE cycle between frames. Frame pitch is 10·`CLK_DIV`+1.
- **Busy:** high from the pop edge until the end of STOP.

## Test plan
Tests 1–4 run with `CLK_DIV`=4 and `FIFO_DEPTH`=4.
1. **Single byte.** Reset, then store 0x55 to DATA in cycle 0.
   - `oTX`=1 in cycles 0–1.
   - Start bit (0) in cycles 2–5.
   - Bits 1,0,1,0,1,0,1,0 in 4-cycle slots.
   - Stop bit (1) in cycles 38–41.
   - STATUS in cycle 42 reads empty=1, busy=0.
2. **Overflow.** Clear `EN`, store 0x01..0x05 on consecutive cycles.
   - STATUS reads full=1, count=4, `OVF`=1.
   - Store 0x2000 to STATUS with `DwByteEnable`=4'b0010 → `OVF`=0.
   - Set `EN` → bytes 0x01..0x04 go out in order, each frame 41 cycles apart.
3. **Push/pop at full.** Fill the FIFO to 4 while a frame is in flight.
   - Store 0xAA in the same cycle as the pop edge → dropped, `OVF`=1, count=3 afterward.
4. **Reset mid-frame.** Assert `iRST` during DATA bit 3.
   - `oTX`=1 and STATUS reads empty=1, busy=0, `OVF`=0, `CTRL`=2'b01, with no clock edge needed.
5. **Decode and IRQ** (default parameters).
   - A load from 0xFF20_0104 while idle returns 0x0000_0002.
   - A load from 0xFF20_0110 returns 0.
   - Byte store with `DwByteEnable`=4'b0010 to DATA → not pushed.
   - Write `CTRL`=2'b11, send 1 byte → `oIRQ` low during the frame, high in the first IDLE cycle after STOP.
